// File: rtl/spi_owner_seq_pkg.sv
// Shared types and constants for the BMC SPI flash ownership sequencer.
// Requester indices match the bit positions of req/gnt.
package spi_owner_seq_pkg;

   typedef enum logic [2:0] {
      IDLE,
      RST_ON,
      SWITCH,
      GRANT,
      HANDOVER,
      RELEASE,
      RST_OFF
   } state_t;

   localparam logic NIOS = 1'b0;
   localparam logic DMA  = 1'b1;

   localparam int GPO_PFR_MASTER_SEL_BIT = 2;
   localparam int GPO_FLASH_RST_N_BIT    = 24;
   localparam int GPO_DMA_NIOS_SEL_BIT   = 26;

   // On a tie the requester that did not own the bus last time wins.
   function automatic logic pick_winner(input logic [1:0] req, input logic last_gnt);
      if (req == 2'b11) begin
         return ~last_gnt;
      end
      return req[DMA];
   endfunction

   function automatic logic [1:0] grant_vec(input logic idx);
      return (idx == DMA) ? 2'b10 : 2'b01;
   endfunction

endpackage

// File: rtl/spi_seq_timer.sv
// Settle timer: loads CYCLES, counts down to zero without wrapping.
// done is high during the last cycle of the settle window.
module spi_seq_timer #(
   parameter int unsigned CYCLES = 16
) (
   input  logic clk,
   input  logic resetn,
   input  logic load,
   output logic done
);

   logic [7:0] cnt;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         cnt <= 8'd0;
      end else if (load) begin
         cnt <= 8'(CYCLES);
      end else if (cnt != 8'd0) begin
         cnt <= cnt - 8'd1;
      end
   end

   assign done = (cnt == 8'd1);

endmodule

// File: rtl/spi_owner_seq.sv
// Arbitrates BMC SPI flash ownership between the Nios SPI master and the DMA
// engine, sequencing flash reset and the PFR mux around every ownership change.
//
// state    | meaning
// ---------+------------------------------------------------------------
// IDLE     | platform owns flash, flash out of reset, waiting for req
// RST_ON   | flash held in reset, dma/nios mux set to winner, settling
// SWITCH   | PFR side takes the flash mux while still in reset, settling
// GRANT    | winner owns the bus; hold counter running
// HANDOVER | grant dropped, dma/nios mux moved to the other requester
// RELEASE  | mux returned to platform, flash still in reset, settling
// RST_OFF  | flash released from reset, settling before IDLE
module spi_owner_seq
   import spi_owner_seq_pkg::*;
#(
   parameter int unsigned SETTLE_CYCLES = 16,
   parameter int unsigned HOLD_MAX      = 4096
) (
   input  logic       clk,
   input  logic       resetn,
   input  logic [1:0] req,
   input  logic       platform_hold,
   output logic [1:0] gnt,
   output logic       pfr_master_sel,
   output logic       dma_nios_sel,
   output logic       flash_rst_n,
   output logic       busy,
   output logic       timeout_err
);

   localparam int HOLD_W = $clog2(HOLD_MAX + 1);

   state_t            state;
   logic              owner;
   logic              last_gnt;
   logic [HOLD_W-1:0] hold_cnt;
   logic              tmr_load;
   logic              tmr_done;

   // The timer sits loaded while no settle is running, and reloads as one
   // settle window ends so back-to-back settle states each get a full window.
   assign tmr_load = (state == IDLE) || (state == GRANT) || tmr_done;

   spi_seq_timer #(
      .CYCLES (SETTLE_CYCLES)
   ) u_timer (
      .clk    (clk),
      .resetn (resetn),
      .load   (tmr_load),
      .done   (tmr_done)
   );

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state          <= IDLE;
         owner          <= NIOS;
         last_gnt       <= DMA;
         hold_cnt       <= '0;
         gnt            <= 2'b00;
         pfr_master_sel <= 1'b0;
         dma_nios_sel   <= 1'b0;
         flash_rst_n    <= 1'b1;
         busy           <= 1'b0;
         timeout_err    <= 1'b0;
      end else begin
         timeout_err <= 1'b0;
         unique case (state)
            IDLE: begin
               if ((req != 2'b00) && !platform_hold) begin
                  state        <= RST_ON;
                  owner        <= pick_winner(req, last_gnt);
                  dma_nios_sel <= pick_winner(req, last_gnt);
                  flash_rst_n  <= 1'b0;
                  busy         <= 1'b1;
               end
            end
            RST_ON: begin
               if (tmr_done) begin
                  state          <= SWITCH;
                  pfr_master_sel <= 1'b1;
               end
            end
            SWITCH: begin
               if (tmr_done) begin
                  state    <= GRANT;
                  gnt      <= grant_vec(owner);
                  last_gnt <= owner;
                  hold_cnt <= HOLD_W'(1);
               end
            end
            GRANT: begin
               // hold_cnt equals the number of GRANT cycles seen so far
               if (hold_cnt == HOLD_W'(HOLD_MAX)) begin
                  state          <= RELEASE;
                  gnt            <= 2'b00;
                  pfr_master_sel <= 1'b0;
                  timeout_err    <= 1'b1;
                  hold_cnt       <= '0;
               end else if (!req[owner]) begin
                  gnt      <= 2'b00;
                  hold_cnt <= '0;
                  if (req[~owner] && !platform_hold) begin
                     state        <= HANDOVER;
                     owner        <= ~owner;
                     dma_nios_sel <= ~owner;
                  end else begin
                     state          <= RELEASE;
                     pfr_master_sel <= 1'b0;
                  end
               end else begin
                  hold_cnt <= hold_cnt + HOLD_W'(1);
               end
            end
            HANDOVER: begin
               if (tmr_done) begin
                  state    <= GRANT;
                  gnt      <= grant_vec(owner);
                  last_gnt <= owner;
                  hold_cnt <= HOLD_W'(1);
               end
            end
            RELEASE: begin
               if (tmr_done) begin
                  state       <= RST_OFF;
                  flash_rst_n <= 1'b1;
               end
            end
            RST_OFF: begin
               if (tmr_done) begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_spi_owner_seq.sv
// Randomized scoreboard bench for spi_owner_seq: a transaction-level model
// predicts when each observable edge happens; a monitor checks them as they occur.
module tb_spi_owner_seq;
   import spi_owner_seq_pkg::*;

   localparam int S  = 16;
   localparam int HM = 100;

   logic       clk;
   logic       resetn;
   logic [1:0] req;
   logic       platform_hold;
   logic [1:0] gnt;
   logic       pfr_master_sel;
   logic       dma_nios_sel;
   logic       flash_rst_n;
   logic       busy;
   logic       timeout_err;

   spi_owner_seq #(
      .SETTLE_CYCLES (S),
      .HOLD_MAX      (HM)
   ) dut (
      .clk            (clk),
      .resetn         (resetn),
      .req            (req),
      .platform_hold  (platform_hold),
      .gnt            (gnt),
      .pfr_master_sel (pfr_master_sel),
      .dma_nios_sel   (dma_nios_sel),
      .flash_rst_n    (flash_rst_n),
      .busy           (busy),
      .timeout_err    (timeout_err)
   );

   typedef struct {
      logic [1:0] v;
      int         c;
   } ev_t;

   // 0 grant, 1 flash_rst_n fall, 2 flash_rst_n rise, 3 pfr fall, 4 busy fall, 5 timeout
   ev_t q_gnt[$];
   ev_t q_frnf[$];
   ev_t q_frnr[$];
   ev_t q_pfrf[$];
   ev_t q_busy[$];
   ev_t q_to[$];

   int   total = 0;
   int   bad   = 0;
   int   cyc   = 0;
   int   last  = 1;
   bit   mon_en = 1'b0;
   logic [1:0] p_gnt = 2'b00;
   logic p_pfr = 1'b0, p_frn = 1'b1, p_busy = 1'b0, p_to = 1'b0;

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #600000;
      $display("FAIL watchdog: got no end of test by cyc %0d, want finish", cyc);
      $fatal(1);
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h (cyc %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic string kname(input int k);
      case (k)
         0:       return "gnt";
         1:       return "frn_fall";
         2:       return "frn_rise";
         3:       return "pfr_fall";
         4:       return "busy_fall";
         default: return "timeout";
      endcase
   endfunction

   task automatic expect_ev(input int kind, input logic [1:0] v, input int c);
      ev_t e;
      e.v = v;
      e.c = c;
      case (kind)
         0:       q_gnt.push_back(e);
         1:       q_frnf.push_back(e);
         2:       q_frnr.push_back(e);
         3:       q_pfrf.push_back(e);
         4:       q_busy.push_back(e);
         default: q_to.push_back(e);
      endcase
   endtask

   task automatic pop_cmp(input int kind);
      ev_t e;
      bit  got;
      got = 1'b0;
      case (kind)
         0:       if (q_gnt.size()  != 0) begin e = q_gnt.pop_front();  got = 1'b1; end
         1:       if (q_frnf.size() != 0) begin e = q_frnf.pop_front(); got = 1'b1; end
         2:       if (q_frnr.size() != 0) begin e = q_frnr.pop_front(); got = 1'b1; end
         3:       if (q_pfrf.size() != 0) begin e = q_pfrf.pop_front(); got = 1'b1; end
         4:       if (q_busy.size() != 0) begin e = q_busy.pop_front(); got = 1'b1; end
         default: if (q_to.size()   != 0) begin e = q_to.pop_front();   got = 1'b1; end
      endcase
      if (!got) begin
         total++;
         bad++;
         $display("FAIL %s_unexpected: got event at cyc %0d want none", kname(kind), cyc);
      end else begin
         chk({kname(kind), "_cyc"}, 32'(cyc), 32'(e.c));
         if (kind == 0) begin
            chk("gnt_val", 32'(gnt), 32'(e.v));
            chk("gnt_dma_nios_sel", 32'(dma_nios_sel), 32'(e.v[1]));
         end
      end
   endtask

   always @(negedge clk) begin
      if (mon_en) begin
         total++;
         if (gnt == 2'b11) begin
            bad++;
            $display("FAIL gnt_onehot: got %b want one-hot or 00", gnt);
         end
         total++;
         if ((pfr_master_sel != p_pfr) && (flash_rst_n != p_frn)) begin
            bad++;
            $display("FAIL pfr_frn_together: got both toggling at cyc %0d want at most one", cyc);
         end
         if ((gnt != p_gnt) && (gnt != 2'b00)) pop_cmp(0);
         if (!flash_rst_n && p_frn)            pop_cmp(1);
         if (flash_rst_n && !p_frn)            pop_cmp(2);
         if (!pfr_master_sel && p_pfr)         pop_cmp(3);
         if (!busy && p_busy)                  pop_cmp(4);
         if (timeout_err)                      pop_cmp(5);
      end
      p_gnt  = gnt;
      p_pfr  = pfr_master_sel;
      p_frn  = flash_rst_n;
      p_busy = busy;
      p_to   = timeout_err;
   end

   task automatic at_cyc(input int x);
      while (cyc < x) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Release leg: mux back at e, flash out of reset S later, IDLE another S later.
   task automatic finish_release(input int e);
      expect_ev(3, 2'b00, e);
      expect_ev(2, 2'b00, e + S);
      expect_ev(4, 2'b00, e + 2 * S);
      at_cyc(e + 2 * S);
   endtask

   // kind: 0 normal, 1 platform_hold before start, 2 timeout, 3 winner drops while settling
   task automatic run_txn(input int kind, input logic [1:0] fpat, input bit force_ho);
      logic [1:0] pat;
      int n, w, g1, d, e, g2, d2, hcyc;
      bit ho, hold_at_drop;
      pat = (fpat != 2'b00) ? fpat : 2'($urandom_range(1, 3));
      if (kind == 1) begin
         at_cyc(cyc + 1);
         platform_hold = 1'b1;
         req = pat;
         hcyc = int'($urandom_range(5, 15));
         for (int i = 0; i < hcyc; i++) begin
            @(negedge clk);
            chk("hold_busy", 32'(busy), 32'd0);
            chk("hold_gnt", 32'(gnt), 32'd0);
         end
         n = cyc;
         platform_hold = 1'b0;
      end else begin
         n = cyc + int'($urandom_range(0, 5));
         at_cyc(n);
         req = pat;
      end
      w  = (pat == 2'b11) ? (1 - last) : ((pat == 2'b10) ? 1 : 0);
      g1 = n + 2 * S + 1;
      expect_ev(1, 2'b00, n + 1);
      expect_ev(0, (w == 1) ? 2'b10 : 2'b01, g1);
      last = w;
      if (kind == 2) begin
         e = g1 + HM;
         expect_ev(5, 2'b00, e);
         at_cyc(e);
         req = 2'b00;
         finish_release(e);
         return;
      end
      ho = (pat == 2'b11) && (force_ho || ($urandom_range(0, 1) == 1));
      hold_at_drop = ho && !force_ho && ($urandom_range(0, 3) == 0);
      if (kind == 3) d = n + int'($urandom_range(1, 2 * S));
      else           d = g1 + int'($urandom_range(0, 40));
      e = ((d > g1) ? d : g1) + 1;
      at_cyc(d);
      if (ho) req[w] = 1'b0;
      else    req = 2'b00;
      if (hold_at_drop) begin
         platform_hold = 1'b1;
         at_cyc(e);
         req = 2'b00;
         platform_hold = 1'b0;
      end else if (ho) begin
         g2 = e + S;
         expect_ev(0, (w == 1) ? 2'b01 : 2'b10, g2);
         last = 1 - w;
         d2 = g2 + int'($urandom_range(0, 30));
         at_cyc(d2);
         req = 2'b00;
         e = d2 + 1;
      end
      finish_release(e);
   endtask

   initial begin
      int g1;
      resetn = 1'b0;
      req = 2'b00;
      platform_hold = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_gnt", 32'(gnt), 32'd0);
      chk("rst_pfr", 32'(pfr_master_sel), 32'd0);
      chk("rst_sel", 32'(dma_nios_sel), 32'd0);
      chk("rst_frn", 32'(flash_rst_n), 32'd1);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_to", 32'(timeout_err), 32'd0);
      resetn = 1'b1;
      mon_en = 1'b1;

      run_txn(0, 2'b11, 1'b1);
      run_txn(0, 2'b01, 1'b0);
      run_txn(2, 2'b10, 1'b0);
      run_txn(0, 2'b11, 1'b0);
      run_txn(1, 2'b01, 1'b0);
      run_txn(3, 2'b11, 1'b1);
      for (int k = 0; k < 24; k++) begin
         run_txn(int'($urandom_range(0, 3)), 2'b00, 1'b0);
      end
      repeat (3) @(negedge clk);
      chk("left_gnt", 32'(q_gnt.size()), 32'd0);
      chk("left_frnf", 32'(q_frnf.size()), 32'd0);
      chk("left_frnr", 32'(q_frnr.size()), 32'd0);
      chk("left_pfrf", 32'(q_pfrf.size()), 32'd0);
      chk("left_busy", 32'(q_busy.size()), 32'd0);
      chk("left_to", 32'(q_to.size()), 32'd0);

      mon_en = 1'b0;
      at_cyc(cyc + 1);
      g1 = cyc + 2 * S + 1;
      req = 2'b01;
      at_cyc(g1 + 2);
      chk("pre_arst_gnt", 32'(gnt), 32'd1);
      chk("pre_arst_pfr", 32'(pfr_master_sel), 32'd1);
      chk("pre_arst_frn", 32'(flash_rst_n), 32'd0);
      #2;
      resetn = 1'b0;
      #1;
      chk("arst_gnt", 32'(gnt), 32'd0);
      chk("arst_pfr", 32'(pfr_master_sel), 32'd0);
      chk("arst_sel", 32'(dma_nios_sel), 32'd0);
      chk("arst_frn", 32'(flash_rst_n), 32'd1);
      chk("arst_busy", 32'(busy), 32'd0);
      chk("arst_to", 32'(timeout_err), 32'd0);
      req = 2'b00;
      #1;
      resetn = 1'b1;
      repeat (3) @(posedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/spi_owner_seq.md
SPI_OWNER_SEQ -- requirements
Module: spi_owner_seq

Interface
REQ-001 SHALL have parameter SETTLE_CYCLES, default 16: cycles to wait after each reset/mux edge (legal 1..255).
REQ-002 SHALL have parameter HOLD_MAX, default 4096: maximum cycles one grant may be held (legal 2..65535).
REQ-003 SHALL have port clk, input, 1: single clock; all logic in this domain.
REQ-004 SHALL have port resetn, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port req, input, 2: bit0 = Nios SPI master request, bit1 = DMA engine request; level, synchronous to clk.
REQ-006 SHALL have port platform_hold, input, 1: 1 blocks new grants; does not affect an active grant.
REQ-007 SHALL have port gnt, output, 2: one-hot or zero; bit i = requester i owns the flash bus.
REQ-008 SHALL have port pfr_master_sel, output, 1: drives GPO bit 2; 1 = PFR side owns the BMC flash.
REQ-009 SHALL have port dma_nios_sel, output, 1: drives GPO bit 26; 1 = DMA, 0 = Nios.
REQ-010 SHALL have port flash_rst_n, output, 1: drives GPO bit 24; active-low flash reset.
REQ-011 SHALL have port busy, output, 1: 1 in every state except IDLE.
REQ-012 SHALL have port timeout_err, output, 1: one-cycle pulse on a forced release.

Function
REQ-013 SHALL implement states IDLE, RST_ON, SWITCH, GRANT, HANDOVER, RELEASE, RST_OFF.
REQ-014 IDLE: pfr_master_sel=0, flash_rst_n=1, gnt=0; if req!=0 and platform_hold=0, SHALL pick a winner and go to RST_ON.
REQ-015 Winner: single requester wins; both requesting -> round-robin, the requester not granted last wins; last-granted pointer resets to 1 (DMA), so Nios wins the first tie.
REQ-016 RST_ON: flash_rst_n=0, dma_nios_sel=winner; SHALL count SETTLE_CYCLES cycles, then go to SWITCH.
REQ-017 SWITCH: pfr_master_sel=1, flash_rst_n=0; after SETTLE_CYCLES, go to GRANT.
REQ-018 GRANT: gnt[winner]=1, flash_rst_n=0, pfr_master_sel=1; the hold counter increments each cycle.
REQ-019 In GRANT, when req[winner] falls: if req[other]=1 and platform_hold=0, go to HANDOVER; else go to RELEASE; gnt SHALL drop in that same transition cycle.
REQ-020 HANDOVER: gnt=0, dma_nios_sel=other, pfr_master_sel stays 1; after SETTLE_CYCLES, go to GRANT with winner=other and the hold counter cleared.
REQ-021 When the hold counter reaches HOLD_MAX in GRANT, SHALL pulse timeout_err, drop gnt and go to RELEASE regardless of req; the timed-out requester loses the next tie.
REQ-022 RELEASE: gnt=0, pfr_master_sel=0, flash_rst_n=0; after SETTLE_CYCLES, go to RST_OFF.
REQ-023 RST_OFF: flash_rst_n=1; after SETTLE_CYCLES, go to IDLE; new requests are ignored until IDLE.
REQ-024 pfr_master_sel and flash_rst_n SHALL never change in the same cycle; the mux switches only while flash_rst_n=0.
REQ-025 Request changes during RST_ON/SWITCH SHALL NOT abort the sequence; if the winner drops, GRANT SHALL be entered and exit next cycle per REQ-019.
REQ-026 All outputs SHALL be registered; grant latency from req rise in IDLE = 2*SETTLE_CYCLES+1 cycles.
REQ-027 The settle counter SHALL be 8 bits and the hold counter $clog2(HOLD_MAX+1) bits; neither SHALL wrap.

Reset
REQ-028 On resetn=0: state=IDLE, gnt=0, pfr_master_sel=0, dma_nios_sel=0, flash_rst_n=1, busy=0, timeout_err=0, counters=0, last-granted=1.
REQ-029 Reset asserted mid-grant SHALL return ownership to the platform immediately, with no settle sequence.

Structure
REQ-030 The state enum, requester index constants (NIOS=0, DMA=1) and GPO bit-position constants for bits 2/24/26 SHALL reside in the shared package spi_owner_seq_pkg.
REQ-031 The settle timer (load, count-down, done pulse) SHALL be a sub-module named spi_seq_timer.

Verification
REQ-032 req=01 from IDLE, SETTLE=16 -> flash_rst_n falls at t+1, pfr_master_sel rises at t+17, gnt=01 at t+33; req=00 -> back to IDLE with flash_rst_n=1 at 2*16 cycles after exit.
REQ-033 req=11 simultaneously after reset -> gnt=01; Nios drops -> HANDOVER, dma_nios_sel=1, gnt=10 after 16 cycles, pfr_master_sel never deasserted.
REQ-034 HOLD_MAX=100, req=10 held -> timeout_err one-cycle pulse on the 100th GRANT cycle, gnt=00, sequence runs RELEASE->RST_OFF->IDLE.
REQ-035 platform_hold=1 with req=01 -> busy=0, gnt=00 indefinitely; hold drops -> grant follows per REQ-026.
REQ-036 resetn pulsed low during GRANT -> all outputs at reset values asynchronously; assertion checks that pfr_master_sel and flash_rst_n never toggle together, and gnt is never 11.
